serial_bus_arbiter_n: RTL and testbench
=======================================

# serial_bus_arbiter_n

Parametrised N-master arbiter for the serial bus: samples per-master request lines, grants one master by fixed-priority or round-robin policy, deserialises the winner's address, and presents it to the address decoder. It then waits for the slave handshake with a timeout and returns a two-bit ack/nack response to the winning master. It sits between the masters' tx lines and the address decoder, and drives the arbiter-side input of each master's read mux.

## Interface
- N_MASTERS, 2: number of masters (2..8).
- ADDR_W, 14: serial address length in bits, MSB first.
- TIMEOUT, 255: maximum cycles spent in WAIT_SLV without slv_ready before a nack (≥1).

- clk  input  1  bus clock; all logic on rising edge.
- rstn  input  1  reset; synchronous, active-low.
- rr_mode  input  1  1 = round-robin, 0 = fixed priority (index 0 highest); sampled only in IDLE.
- m_tx  input  N_MASTERS  per-master serial tx; idle low; held high to request; carries address bits after grant.
- m_rx  output  N_MASTERS  per-master arbiter-side rx (grant strobe, response bits); idle low.
- addr  output  ADDR_W  deserialised address; valid from the addr_rdy cycle until return to IDLE.
- addr_rdy  output  1  one-cycle strobe, address valid.
- gnt  output  N_MASTERS  one-hot current owner; all-zero in IDLE.
- busy  output  1  high in every state except IDLE.
- slv_ready  input  1  decoder: addressed slave accepted.
- slv_responded  input  1  decoder: slave transaction complete.
- timeout_err  output  1  one-cycle strobe when the slave wait expires.

## Operation
- States: IDLE, GRANT, ADDR, WAIT_SLV, RESP1, RESP2, HOLD.
- IDLE: the request vector is m_tx.
  - No request: stay in IDLE.
  - Fixed mode: the winner is the lowest set index.
  - Round-robin mode: the winner is the first set index searching from rr_ptr+1 with wrap; rr_ptr is then updated to the winner.
  - Go to GRANT.
- GRANT (1 cycle): m_rx[w]=1 and gnt[w]=1. Clear the shift register and bit counter. Go to ADDR.
- ADDR (ADDR_W cycles): shift m_tx[w] into addr LSB each cycle, so the first bit ends up as the MSB. After ADDR_W bits, go to WAIT_SLV.
- WAIT_SLV:
  - addr_rdy=1 on the first cycle only.
  - The timeout counter increments each cycle.
  - slv_ready=1: go to RESP1 with ack=1.
  - Counter reaches TIMEOUT without slv_ready: pulse timeout_err and go to RESP1 with ack=0.
  - slv_ready in the same cycle as expiry: ack wins; no timeout_err.
- RESP1: m_rx[w]=1 (response strobe).
- RESP2: m_rx[w]=ack.
  - ack=0: go to IDLE.
  - ack=1 and slv_responded already latched: go to IDLE.
  - Otherwise: go to HOLD.
- HOLD: wait for slv_responded, then go to IDLE.
- slv_responded handling:
  - Latched from RESP1 onward.
  - Ignored in WAIT_SLV before slv_ready.
  - Latch cleared on entering IDLE.
- Requests from non-owners are ignored while busy. Masters keep m_tx high until they see their grant strobe.
- Only gnt's owner can see non-zero m_rx. At most one m_rx bit is high in any cycle.
- Reset (any state, including mid-address or HOLD):
  - Next cycle is IDLE.
  - m_rx, gnt, addr_rdy, timeout_err, busy and addr are all 0.
  - rr_ptr = N_MASTERS-1, so master 0 has first priority.
  - Timeout counter, slv_responded latch and shift register are cleared.
- Timeout counter width is $clog2(TIMEOUT+1). It saturates and never wraps.

## Timing
- Request high in IDLE at cycle T:
  - GRANT at T+1 (m_rx[w]=1, gnt and busy rise).
  - Address bits sampled at T+2 .. T+1+ADDR_W.
  - addr_rdy at T+2+ADDR_W.
- slv_ready at cycle S: RESP1 at S+1, RESP2 at S+2, then HOLD or IDLE at S+3.
- slv_responded at cycle R in HOLD: IDLE at R+1. A new grant is possible at R+2 at the earliest.
- Nack path: timeout_err is high in the last WAIT_SLV cycle, which is the TIMEOUT-th cycle counted from addr_rdy. RESP1 and RESP2 follow, then IDLE.
- All outputs are registered.

## Test plan
- Single request, N_MASTERS=2, ADDR_W=14, m1 sends 0x2A5C, slave asserts slv_ready 3 cycles after addr_rdy and slv_responded 10 cycles later -> gnt=01, addr_rdy with addr=0x2A5C, m_rx[0] pattern 1,0…,1,1, IDLE one cycle after slv_responded.
- Simultaneous requests, fixed mode, three back-to-back transactions with both masters requesting -> master 0 wins every time.
- Simultaneous requests, rr_mode=1, N_MASTERS=4 with all requesting -> grant order 0,1,2,3,0.
- No slave response, TIMEOUT=8 -> timeout_err pulses 8 cycles after addr_rdy, m_rx[w] RESP sequence 1 then 0, IDLE, no HOLD.
- slv_ready asserted in the expiry cycle -> ack=1, no timeout_err. slv_responded in RESP1 -> skips HOLD.
- rstn low mid-ADDR and again in HOLD -> next cycle all outputs 0. Then a fresh rr_mode=1 request from all masters grants master 0.

Source files
------------

// File: rtl/serial_bus_arbiter_n.sv
// serial_bus_arbiter_n
//
// N-master serial bus arbiter. Samples the masters' request lines while idle,
// picks one owner (fixed priority or round-robin), deserialises that master's
// address MSB first, presents it to the address decoder, waits for the slave
// handshake with a timeout and returns a two-bit response on the owner's rx.
//
// Ports
//   clk            bus clock, rising edge
//   rstn           synchronous active-low reset
//   rr_mode        1 = round-robin, 0 = fixed priority (index 0 highest)
//   m_tx           per-master serial tx (request level / address bits)
//   m_rx           per-master arbiter-side rx (grant strobe, response bits)
//   addr           deserialised address
//   addr_rdy       one-cycle strobe, address valid
//   gnt            one-hot current owner, zero in IDLE
//   busy           high in every state except IDLE
//   slv_ready      decoder: addressed slave accepted
//   slv_responded  decoder: slave transaction complete
//   timeout_err    one-cycle strobe when the slave wait expires
module serial_bus_arbiter_n #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 14,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rr_mode,
    input  logic [N_MASTERS-1:0] m_tx,
    output logic [N_MASTERS-1:0] m_rx,
    output logic [ADDR_W-1:0]    addr,
    output logic                 addr_rdy,
    output logic [N_MASTERS-1:0] gnt,
    output logic                 busy,
    input  logic                 slv_ready,
    input  logic                 slv_responded,
    output logic                 timeout_err
);

    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int BIT_W = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GRANT = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP1 = 3'd4;
    localparam logic [2:0] S_RESP2 = 3'd5;
    localparam logic [2:0] S_HOLD  = 3'd6;

    logic [2:0]           state_reg, state_next;
    logic [IDX_W-1:0]     owner_reg, owner_next;
    logic [IDX_W-1:0]     rr_ptr_reg, rr_ptr_next;
    logic                 ack_reg, ack_next;
    logic                 resp_seen_reg, resp_seen_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [BIT_W-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [ADDR_W-1:0]    shift_reg, shift_next;
    logic                 timeout_err_reg, timeout_next;
    logic                 addr_rdy_reg, addr_rdy_next;
    logic [N_MASTERS-1:0] m_rx_reg;
    logic [N_MASTERS-1:0] gnt_reg;
    logic                 busy_reg;

    logic [IDX_W-1:0]     fixed_win;
    logic [IDX_W-1:0]     rr_win;
    logic [IDX_W-1:0]     rr_idx;
    logic [N_MASTERS-1:0] owner_onehot;

    // Winner selection. Loops run from lowest to highest priority so the last
    // match (the highest priority one) sticks.
    always_comb begin
        fixed_win = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (m_tx[i]) begin
                fixed_win = IDX_W'(i);
            end
        end

        rr_win = rr_ptr_reg;
        rr_idx = '0;
        for (int k = N_MASTERS; k >= 1; k--) begin
            rr_idx = IDX_W'((int'(rr_ptr_reg) + k) % N_MASTERS);
            if (m_tx[rr_idx]) begin
                rr_win = rr_idx;
            end
        end
    end

    // Outputs are registered from the next-state values, so the one-hot
    // owner is decoded from owner_next.
    generate
        for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_onehot
            assign owner_onehot[gi] = (owner_next == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        rr_ptr_next    = rr_ptr_reg;
        ack_next       = ack_reg;
        resp_seen_next = resp_seen_reg;
        cnt_next       = cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        timeout_next   = 1'b0;
        addr_rdy_next  = 1'b0;

        case (state_reg)
            S_IDLE: begin
                resp_seen_next = 1'b0;
                cnt_next       = '0;
                if (|m_tx) begin
                    state_next = S_GRANT;
                    if (rr_mode) begin
                        owner_next  = rr_win;
                        rr_ptr_next = rr_win;
                    end else begin
                        owner_next = fixed_win;
                    end
                end
            end

            S_GRANT: begin
                shift_next   = '0;
                bit_cnt_next = '0;
                cnt_next     = '0;
                ack_next     = 1'b0;
                state_next   = S_ADDR;
            end

            S_ADDR: begin
                shift_next = (shift_reg << 1) | ADDR_W'(m_tx[owner_reg]);
                if (bit_cnt_reg == BIT_W'(ADDR_W - 1)) begin
                    state_next    = S_WAIT;
                    addr_rdy_next = 1'b1;
                end else begin
                    bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                end
            end

            S_WAIT: begin
                // The expiry decision is taken in the cycle the counter
                // reaches TIMEOUT; a slv_ready there still wins. Otherwise
                // timeout_err is shown in one extra, final WAIT cycle so it
                // can come straight from a register.
                if (timeout_err_reg) begin
                    state_next = S_RESP1;
                    ack_next   = 1'b0;
                end else if (slv_ready) begin
                    state_next = S_RESP1;
                    ack_next   = 1'b1;
                end else begin
                    if (cnt_reg != CNT_W'(TIMEOUT)) begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                    if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                        timeout_next = 1'b1;
                    end
                end
            end

            S_RESP1: begin
                resp_seen_next = resp_seen_reg | slv_responded;
                state_next     = S_RESP2;
            end

            S_RESP2: begin
                resp_seen_next = resp_seen_reg | slv_responded;
                if (!ack_reg || resp_seen_reg) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_HOLD;
                end
            end

            S_HOLD: begin
                if (resp_seen_reg || slv_responded) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg       <= S_IDLE;
            owner_reg       <= '0;
            rr_ptr_reg      <= IDX_W'(N_MASTERS - 1);
            ack_reg         <= 1'b0;
            resp_seen_reg   <= 1'b0;
            cnt_reg         <= '0;
            bit_cnt_reg     <= '0;
            shift_reg       <= '0;
            timeout_err_reg <= 1'b0;
            addr_rdy_reg    <= 1'b0;
            m_rx_reg        <= '0;
            gnt_reg         <= '0;
            busy_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            owner_reg       <= owner_next;
            rr_ptr_reg      <= rr_ptr_next;
            ack_reg         <= ack_next;
            resp_seen_reg   <= resp_seen_next;
            cnt_reg         <= cnt_next;
            bit_cnt_reg     <= bit_cnt_next;
            shift_reg       <= shift_next;
            timeout_err_reg <= timeout_next;
            addr_rdy_reg    <= addr_rdy_next;
            busy_reg        <= (state_next != S_IDLE);
            gnt_reg         <= (state_next != S_IDLE) ? owner_onehot : '0;
            // Grant strobe, response strobe, then the ack bit.
            if ((state_next == S_GRANT) || (state_next == S_RESP1) ||
                ((state_next == S_RESP2) && ack_next)) begin
                m_rx_reg <= owner_onehot;
            end else begin
                m_rx_reg <= '0;
            end
        end
    end

    assign m_rx        = m_rx_reg;
    assign gnt         = gnt_reg;
    assign busy        = busy_reg;
    assign addr        = shift_reg;
    assign addr_rdy    = addr_rdy_reg;
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_serial_bus_arbiter_n.sv
// Directed testbench for serial_bus_arbiter_n (4 masters, 14-bit address,
// timeout of 8 cycles). Inputs change 1 time unit after the rising edge and
// outputs are observed at that same point, i.e. for the current cycle.
module tb_serial_bus_arbiter_n;

    localparam int NM = 4;
    localparam int AW = 14;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          rr_mode;
    logic [NM-1:0] m_tx;
    logic [NM-1:0] m_rx;
    logic [AW-1:0] addr;
    logic          addr_rdy;
    logic [NM-1:0] gnt;
    logic          busy;
    logic          slv_ready;
    logic          slv_responded;
    logic          timeout_err;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    serial_bus_arbiter_n #(
        .N_MASTERS(NM),
        .ADDR_W   (AW),
        .TIMEOUT  (TO)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .rr_mode      (rr_mode),
        .m_tx         (m_tx),
        .m_rx         (m_rx),
        .addr         (addr),
        .addr_rdy     (addr_rdy),
        .gnt          (gnt),
        .busy         (busy),
        .slv_ready    (slv_ready),
        .slv_responded(slv_responded),
        .timeout_err  (timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rstn          = 1'b0;
        m_tx          = '0;
        slv_ready     = 1'b0;
        slv_responded = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    // From an IDLE cycle: raise mask, expect master w granted, shift in a.
    // Returns in the first WAIT_SLV cycle (addr_rdy).
    task automatic send_addr(input logic [NM-1:0] mask, input int w, input logic [AW-1:0] a);
        logic [NM-1:0] exp_oh;
        exp_oh    = '0;
        exp_oh[w] = 1'b1;
        m_tx      = mask;
        tick();
        tests_run++;
        if (gnt !== exp_oh) begin
            tests_failed++;
            $display("FAIL grant_gnt: gnt=%b expected %b", gnt, exp_oh);
        end
        tests_run++;
        if (m_rx !== exp_oh) begin
            tests_failed++;
            $display("FAIL grant_strobe: m_rx=%b expected %b", m_rx, exp_oh);
        end
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL grant_busy: busy=%b expected 1", busy);
        end
        m_tx[w] = 1'b0;
        for (int i = 0; i < AW; i++) begin
            tick();
            m_tx[w] = a[AW-1-i];
            if (i == 0) begin
                tests_run++;
                if (m_rx !== '0 || addr_rdy !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL addr_phase_quiet: m_rx=%b addr_rdy=%b expected 0000/0", m_rx, addr_rdy);
                end
            end
        end
        tick();
        m_tx[w] = 1'b0;
        tests_run++;
        if (addr_rdy !== 1'b1) begin
            tests_failed++;
            $display("FAIL addr_rdy: addr_rdy=%b expected 1", addr_rdy);
        end
        tests_run++;
        if (addr !== a) begin
            tests_failed++;
            $display("FAIL addr_value: addr=%h expected %h", addr, a);
        end
        $display("[TB] txn master=%0d addr=%h gnt=%b", w, addr, gnt);
    endtask

    // From the addr_rdy cycle: slave accepts at once and completes in RESP1.
    task automatic finish_fast(input int w);
        logic [NM-1:0] exp_oh;
        exp_oh    = '0;
        exp_oh[w] = 1'b1;
        slv_ready = 1'b1;
        tick();
        slv_ready     = 1'b0;
        slv_responded = 1'b1;
        tests_run++;
        if (m_rx !== exp_oh) begin
            tests_failed++;
            $display("FAIL fast_resp1: m_rx=%b expected %b", m_rx, exp_oh);
        end
        tick();
        slv_responded = 1'b0;
        tests_run++;
        if (m_rx !== exp_oh) begin
            tests_failed++;
            $display("FAIL fast_resp2_ack: m_rx=%b expected %b", m_rx, exp_oh);
        end
        tick();
        tests_run++;
        if (busy !== 1'b0 || gnt !== '0 || m_rx !== '0) begin
            tests_failed++;
            $display("FAIL fast_idle: busy=%b gnt=%b m_rx=%b expected 0/0000/0000", busy, gnt, m_rx);
        end
    endtask

    task automatic check_all_zero(input string tag);
        tests_run++;
        if (m_rx !== '0 || gnt !== '0 || busy !== 1'b0 || addr_rdy !== 1'b0 ||
            timeout_err !== 1'b0 || addr !== '0) begin
            tests_failed++;
            $display("FAIL %s: m_rx=%b gnt=%b busy=%b addr_rdy=%b timeout_err=%b addr=%h expected all zero",
                     tag, m_rx, gnt, busy, addr_rdy, timeout_err, addr);
        end
        $display("[TB] %s m_rx=%b gnt=%b busy=%b addr=%h", tag, m_rx, gnt, busy, addr);
    endtask

    task automatic test_reset();
        rstn          = 1'b0;
        rr_mode       = 1'b0;
        m_tx          = 4'b1111;
        slv_ready     = 1'b0;
        slv_responded = 1'b0;
        tick();
        tick();
        check_all_zero("reset_state");
        m_tx = '0;
        rstn = 1'b1;
    endtask

    task automatic test_single();
        rr_mode = 1'b0;
        send_addr(4'b0001, 0, 14'h2A5C);
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (m_rx !== '0 || addr_rdy !== 1'b0 || timeout_err !== 1'b0) begin
                tests_failed++;
                $display("FAIL single_wait: m_rx=%b addr_rdy=%b timeout_err=%b expected 0000/0/0", m_rx, addr_rdy, timeout_err);
            end
        end
        slv_ready = 1'b1;
        tick();
        slv_ready = 1'b0;
        tests_run++;
        if (m_rx !== 4'b0001) begin
            tests_failed++;
            $display("FAIL single_resp1: m_rx=%b expected 0001", m_rx);
        end
        tick();
        tests_run++;
        if (m_rx !== 4'b0001) begin
            tests_failed++;
            $display("FAIL single_resp2: m_rx=%b expected 0001", m_rx);
        end
        tick();
        tests_run++;
        if (m_rx !== '0 || busy !== 1'b1 || gnt !== 4'b0001 || addr !== 14'h2A5C) begin
            tests_failed++;
            $display("FAIL single_hold: m_rx=%b busy=%b gnt=%b addr=%h expected 0000/1/0001/2a5c", m_rx, busy, gnt, addr);
        end
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_hold_late: busy=%b expected 1", busy);
        end
        slv_responded = 1'b1;
        tick();
        slv_responded = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || gnt !== '0 || m_rx !== '0) begin
            tests_failed++;
            $display("FAIL single_idle: busy=%b gnt=%b m_rx=%b expected 0/0000/0000", busy, gnt, m_rx);
        end
        $display("[TB] single transaction done busy=%b", busy);
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] addrs [3];
        addrs[0] = 14'h1234;
        addrs[1] = 14'h0F0F;
        addrs[2] = 14'h3FFF;
        rr_mode  = 1'b0;
        for (int t = 0; t < 3; t++) begin
            send_addr(4'b0011, 0, addrs[t]);
            finish_fast(0);
        end
        m_tx = '0;
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] addrs [5];
        addrs[0] = 14'h0001;
        addrs[1] = 14'h2000;
        addrs[2] = 14'h1555;
        addrs[3] = 14'h2AAA;
        addrs[4] = 14'h0000;
        reset_dut();
        rr_mode = 1'b1;
        for (int t = 0; t < 5; t++) begin
            send_addr(4'b1111, t % 4, addrs[t]);
            finish_fast(t % 4);
        end
        m_tx    = '0;
        rr_mode = 1'b0;
    endtask

    task automatic test_timeout();
        rr_mode = 1'b0;
        send_addr(4'b0010, 1, 14'h0A0A);
        for (int i = 1; i < TO; i++) begin
            tick();
            tests_run++;
            if (timeout_err !== 1'b0 || m_rx !== '0) begin
                tests_failed++;
                $display("FAIL timeout_early: cycle=%0d timeout_err=%b m_rx=%b expected 0/0000", i, timeout_err, m_rx);
            end
        end
        tick();
        tests_run++;
        if (timeout_err !== 1'b1 || busy !== 1'b1 || m_rx !== '0) begin
            tests_failed++;
            $display("FAIL timeout_pulse: timeout_err=%b busy=%b m_rx=%b expected 1/1/0000", timeout_err, busy, m_rx);
        end
        tick();
        tests_run++;
        if (timeout_err !== 1'b0 || m_rx !== 4'b0010) begin
            tests_failed++;
            $display("FAIL timeout_resp1: timeout_err=%b m_rx=%b expected 0/0010", timeout_err, m_rx);
        end
        tick();
        tests_run++;
        if (m_rx !== '0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_resp2_nack: m_rx=%b busy=%b expected 0000/1", m_rx, busy);
        end
        tick();
        tests_run++;
        if (busy !== 1'b0 || gnt !== '0) begin
            tests_failed++;
            $display("FAIL timeout_idle: busy=%b gnt=%b expected 0/0000", busy, gnt);
        end
        $display("[TB] timeout transaction done busy=%b", busy);
    endtask

    task automatic test_ready_at_expiry();
        rr_mode = 1'b0;
        send_addr(4'b0100, 2, 14'h3C3C);
        for (int i = 1; i < TO; i++) begin
            tick();
        end
        tests_run++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL expiry_cycle: timeout_err=%b busy=%b expected 0/1", timeout_err, busy);
        end
        slv_ready = 1'b1;
        tick();
        slv_ready     = 1'b0;
        slv_responded = 1'b1;
        tests_run++;
        if (timeout_err !== 1'b0 || m_rx !== 4'b0100) begin
            tests_failed++;
            $display("FAIL expiry_resp1: timeout_err=%b m_rx=%b expected 0/0100", timeout_err, m_rx);
        end
        tick();
        slv_responded = 1'b0;
        tests_run++;
        if (timeout_err !== 1'b0 || m_rx !== 4'b0100) begin
            tests_failed++;
            $display("FAIL expiry_resp2_ack: timeout_err=%b m_rx=%b expected 0/0100", timeout_err, m_rx);
        end
        tick();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL expiry_skip_hold: busy=%b expected 0", busy);
        end
        $display("[TB] ready-at-expiry transaction done busy=%b", busy);
    endtask

    task automatic test_reset_mid();
        reset_dut();
        rr_mode = 1'b0;
        // Abort mid-address.
        m_tx = 4'b0100;
        tick();
        m_tx = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            m_tx[2] = 1'b1;
        end
        rstn = 1'b0;
        m_tx = '0;
        tick();
        check_all_zero("reset_mid_addr");
        rstn = 1'b1;
        // Round-robin transaction to master 0, then abort in HOLD.
        rr_mode = 1'b1;
        send_addr(4'b1111, 0, 14'h1111);
        slv_ready = 1'b1;
        tick();
        slv_ready = 1'b0;
        tick();
        tick();
        tests_run++;
        if (busy !== 1'b1 || m_rx !== '0) begin
            tests_failed++;
            $display("FAIL reset_pre_hold: busy=%b m_rx=%b expected 1/0000", busy, m_rx);
        end
        rstn = 1'b0;
        m_tx = '0;
        tick();
        check_all_zero("reset_in_hold");
        rstn = 1'b1;
        // Pointer was restored, so master 0 wins again.
        send_addr(4'b1111, 0, 14'h2222);
        finish_fast(0);
        m_tx    = '0;
        rr_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_round_robin();
        test_timeout();
        test_ready_at_expiry();
        test_reset_mid();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
